// File: rtl/race_start_gate_pkg.sv
// race_pkg: shared types and constants for the race start gate.
//   race_state_t    : gate FSM states.
//   GREEN..YELLOW   : bit index of each player in the 4-bit player vectors.
//   COUNTDOWN_START : first digit shown by the start lights.
//   max3()          : used to size the shared timer from the tick parameters.
package race_pkg;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      ARM       = 3'd1,
      COUNTDOWN = 3'd2,
      RACE      = 3'd3,
      FINISHED  = 3'd4
   } race_state_t;

   localparam int NUM_PLAYERS = 4;
   localparam int GREEN       = 0;
   localparam int RED         = 1;
   localparam int BLUE        = 2;
   localparam int YELLOW      = 3;

   localparam logic [1:0] COUNTDOWN_START = 2'd3;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/race_start_gate_if.sv
// race_start_gate_if: groups the button, finish and core-facing signals.
//   slave  : seen by race_start_gate (buttons/finish in, pulses/status out).
//   master : seen by whatever drives the buttons and consumes the outputs.
interface race_start_gate_if;
   import race_pkg::*;

   logic                   btn_green;
   logic                   btn_red;
   logic                   btn_blue;
   logic                   btn_yellow;
   logic                   finish;
   logic                   step_green;
   logic                   step_red;
   logic                   step_blue;
   logic                   step_yellow;
   logic                   game_clear;
   logic [1:0]             countdown;
   logic                   race_active;
   logic [NUM_PLAYERS-1:0] false_start;

   modport slave (
      input  btn_green, btn_red, btn_blue, btn_yellow, finish,
      output step_green, step_red, step_blue, step_yellow,
             game_clear, countdown, race_active, false_start
   );

   modport master (
      output btn_green, btn_red, btn_blue, btn_yellow, finish,
      input  step_green, step_red, step_blue, step_yellow,
             game_clear, countdown, race_active, false_start
   );

endinterface

// File: rtl/race_start_gate_press_edge_detect.sv
// press_edge_detect: rising-edge detector on the debounced button levels.
//   clk, rst_n : clock and synchronous active-low reset.
//   btn        : debounced levels {yellow,blue,red,green}, 1 = pressed.
//   press      : high for the one cycle in which a level is first seen high.
module press_edge_detect
   import race_pkg::*;
(
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [NUM_PLAYERS-1:0] btn,
   output logic [NUM_PLAYERS-1:0] press
);

   logic [NUM_PLAYERS-1:0] prev_r;

   // Button history; resets to all ones so a button held through reset is not a press.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         prev_r <= {NUM_PLAYERS{1'b1}};
      end else begin
         prev_r <= btn;
      end
   end

   assign press = btn & ~prev_r;

endmodule

// File: rtl/race_start_gate.sv
// race_start_gate: converts debounced buttons into step pulses and runs the
// 3-2-1 start countdown, false-start penalty and post-finish hold.
//   clk, rst_n : clock and synchronous active-low reset.
//   bus        : race_start_gate_if.slave
//                in : btn_green/red/blue/yellow, finish
//                out: step_green/red/blue/yellow, game_clear, countdown,
//                     race_active, false_start {yellow,blue,red,green}
// All outputs come straight from registers.
module race_start_gate
   import race_pkg::*;
#(
   parameter int TICKS_PER_PHASE = 50000000,
   parameter int PENALTY_TICKS   = 25000000,
   parameter int HOLD_TICKS      = 150000000
) (
   input  logic              clk,
   input  logic              rst_n,
   race_start_gate_if.slave  bus
);

   // One down-counter serves all three phases, so size it for the longest.
   localparam int MAX_TICKS = max3(TICKS_PER_PHASE, PENALTY_TICKS, HOLD_TICKS);
   localparam int TIMER_W   = (MAX_TICKS > 1) ? $clog2(MAX_TICKS) : 1;

   localparam logic [TIMER_W-1:0] TIMER_ZERO   = {TIMER_W{1'b0}};
   localparam logic [TIMER_W-1:0] TIMER_ONE    = {{(TIMER_W-1){1'b0}}, 1'b1};
   localparam logic [TIMER_W-1:0] PHASE_LOAD   = TIMER_W'(TICKS_PER_PHASE - 1);
   localparam logic [TIMER_W-1:0] PENALTY_LOAD = TIMER_W'(PENALTY_TICKS - 1);
   localparam logic [TIMER_W-1:0] HOLD_LOAD    = TIMER_W'(HOLD_TICKS - 1);

   race_state_t            state_r, state_s;
   logic [TIMER_W-1:0]     timer_r, timer_s;
   logic [1:0]             countdown_r, countdown_s;
   logic                   race_active_r, race_active_s;
   logic [NUM_PLAYERS-1:0] false_start_r, false_start_s;
   logic [NUM_PLAYERS-1:0] step_r, step_s;
   logic                   game_clear_r, game_clear_s;
   logic [NUM_PLAYERS-1:0] btn_s;
   logic [NUM_PLAYERS-1:0] press_s;
   logic                   penalty_on_s;

   assign btn_s = {bus.btn_yellow, bus.btn_blue, bus.btn_red, bus.btn_green};

   press_edge_detect u_press (
      .clk   (clk),
      .rst_n (rst_n),
      .btn   (btn_s),
      .press (press_s)
   );

   // In RACE the timer counts the penalty window; it saturates at zero.
   assign penalty_on_s = (timer_r != TIMER_ZERO);

   // Next-state and next-output logic for the gate FSM.
   always_comb begin
      state_s       = state_r;
      timer_s       = timer_r;
      countdown_s   = countdown_r;
      race_active_s = race_active_r;
      false_start_s = false_start_r;
      step_s        = {NUM_PLAYERS{1'b0}};
      game_clear_s  = 1'b0;

      case (state_r)
         IDLE: begin
            if (|press_s) begin
               state_s = ARM;
            end else begin
               state_s = IDLE;
            end
         end

         // Hold off the countdown until every button is released.
         ARM: begin
            if (btn_s == {NUM_PLAYERS{1'b0}}) begin
               state_s       = COUNTDOWN;
               game_clear_s  = 1'b1;
               false_start_s = {NUM_PLAYERS{1'b0}};
               countdown_s   = COUNTDOWN_START;
               timer_s       = PHASE_LOAD;
            end else begin
               state_s = ARM;
            end
         end

         // Presses here only mark false starts; they never move a player.
         COUNTDOWN: begin
            false_start_s = false_start_r | press_s;
            if (timer_r != TIMER_ZERO) begin
               timer_s = timer_r - TIMER_ONE;
            end else if (countdown_r > 2'd1) begin
               countdown_s = countdown_r - 2'd1;
               timer_s     = PHASE_LOAD;
            end else begin
               state_s       = RACE;
               countdown_s   = 2'd0;
               race_active_s = 1'b1;
               timer_s       = PENALTY_LOAD;
            end
         end

         // finish wins over any press sampled in the same cycle.
         RACE: begin
            if (bus.finish) begin
               state_s       = FINISHED;
               race_active_s = 1'b0;
               timer_s       = HOLD_LOAD;
            end else begin
               step_s = press_s & ~(false_start_r & {NUM_PLAYERS{penalty_on_s}});
               if (penalty_on_s) begin
                  timer_s = timer_r - TIMER_ONE;
               end else begin
                  timer_s = TIMER_ZERO;
               end
            end
         end

         FINISHED: begin
            if (timer_r == TIMER_ZERO) begin
               state_s = IDLE;
            end else begin
               timer_s = timer_r - TIMER_ONE;
            end
         end

         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // State, timer and output registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r       <= IDLE;
         timer_r       <= TIMER_ZERO;
         countdown_r   <= 2'd0;
         race_active_r <= 1'b0;
         false_start_r <= {NUM_PLAYERS{1'b0}};
         step_r        <= {NUM_PLAYERS{1'b0}};
         game_clear_r  <= 1'b0;
      end else begin
         state_r       <= state_s;
         timer_r       <= timer_s;
         countdown_r   <= countdown_s;
         race_active_r <= race_active_s;
         false_start_r <= false_start_s;
         step_r        <= step_s;
         game_clear_r  <= game_clear_s;
      end
   end

   assign bus.step_green  = step_r[GREEN];
   assign bus.step_red    = step_r[RED];
   assign bus.step_blue   = step_r[BLUE];
   assign bus.step_yellow = step_r[YELLOW];
   assign bus.game_clear  = game_clear_r;
   assign bus.countdown   = countdown_r;
   assign bus.race_active = race_active_r;
   assign bus.false_start = false_start_r;

endmodule

// File: tb/tb_race_start_gate.sv
// tb_race_start_gate: scenario tasks for race_start_gate with
// TICKS_PER_PHASE=4, PENALTY_TICKS=6, HOLD_TICKS=8. Expected step pulses are
// queued when a press is driven and checked every cycle by a monitor; the
// tasks check countdown/status outputs inline.
module tb_race_start_gate;

   logic clk;
   logic rst_n;
   int   vectors     = 0;
   int   miscompares = 0;
   int   cyc         = 0;
   bit   mon_en      = 1'b0;

   typedef struct {
      int         cyc;
      logic [3:0] vec;
   } exp_t;

   exp_t sb_q[$];

   race_start_gate_if bus ();

   race_start_gate #(
      .TICKS_PER_PHASE (4),
      .PENALTY_TICKS   (6),
      .HOLD_TICKS      (8)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Cycle number = count of rising edges seen so far.
   always @(posedge clk) cyc <= cyc + 1;

   // Every cycle the step vector must match the queued expectation, or be zero.
   always @(negedge clk) begin
      logic [3:0] exp_v;
      logic [3:0] act_v;
      if (mon_en) begin
         exp_v = 4'b0000;
         if (sb_q.size() > 0 && sb_q[0].cyc == cyc) begin
            exp_v = sb_q[0].vec;
            sb_q.delete(0);
         end
         act_v = {bus.step_yellow, bus.step_blue, bus.step_red, bus.step_green};
         vectors++;
         if (act_v !== exp_v) begin
            miscompares++;
            $display("FAIL step_vec cyc=%0d: got %b expected %b", cyc, act_v, exp_v);
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // v = {yellow, blue, red, green}
   task automatic set_btn(input logic [3:0] v);
      bus.btn_green  = v[0];
      bus.btn_red    = v[1];
      bus.btn_blue   = v[2];
      bus.btn_yellow = v[3];
   endtask

   // A press driven now is sampled on the next edge and steps in that cycle.
   task automatic push_step(input logic [3:0] v);
      exp_t e;
      e.cyc = cyc + 1;
      e.vec = v;
      sb_q.push_back(e);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tick(1);
      rst_n = 1'b1;
      tick(1);
   endtask

   // Press and release green from IDLE; returns in the game_clear cycle.
   task automatic start_game();
      set_btn(4'b0001);
      tick(1);
      set_btn(4'b0000);
      tick(1);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      set_btn(4'b0010);
      tick(2);
      mon_en = 1'b1;
      vectors++; if (bus.countdown !== 2'd0) begin miscompares++; $display("FAIL rst_countdown: got %0d expected 0", bus.countdown); end
      vectors++; if (bus.race_active !== 1'b0) begin miscompares++; $display("FAIL rst_race_active: got %b expected 0", bus.race_active); end
      vectors++; if (bus.false_start !== 4'b0000) begin miscompares++; $display("FAIL rst_false_start: got %b expected 0000", bus.false_start); end
      vectors++; if (bus.game_clear !== 1'b0) begin miscompares++; $display("FAIL rst_game_clear: got %b expected 0", bus.game_clear); end
      rst_n = 1'b1;
      tick(3);
      set_btn(4'b0000);
      for (int i = 0; i < 4; i++) begin
         tick(1);
         vectors++; if (bus.game_clear !== 1'b0) begin miscompares++; $display("FAIL held_no_arm: got %b expected 0", bus.game_clear); end
      end
      set_btn(4'b0010);
      tick(1);
      vectors++; if (bus.game_clear !== 1'b0) begin miscompares++; $display("FAIL arm_wait1: got %b expected 0", bus.game_clear); end
      tick(1);
      vectors++; if (bus.game_clear !== 1'b0) begin miscompares++; $display("FAIL arm_wait2: got %b expected 0", bus.game_clear); end
      set_btn(4'b0000);
      tick(1);
      vectors++; if (bus.game_clear !== 1'b1) begin miscompares++; $display("FAIL clear_pulse: got %b expected 1", bus.game_clear); end
      vectors++; if (bus.countdown !== 2'd3) begin miscompares++; $display("FAIL clear_countdown: got %0d expected 3", bus.countdown); end
      tick(1);
      vectors++; if (bus.game_clear !== 1'b0) begin miscompares++; $display("FAIL clear_width: got %b expected 0", bus.game_clear); end
   endtask

   task automatic test_countdown();
      logic [1:0] exp_cd;
      do_reset();
      start_game();
      vectors++; if (bus.game_clear !== 1'b1) begin miscompares++; $display("FAIL cd_clear: got %b expected 1", bus.game_clear); end
      for (int d = 3; d >= 1; d--) begin
         for (int i = 0; i < 4; i++) begin
            // A finish pulse outside RACE must be ignored.
            bus.finish = (d == 3 && i == 1);
            exp_cd = 2'(d);
            vectors++; if (bus.countdown !== exp_cd) begin miscompares++; $display("FAIL cd_digit d=%0d i=%0d: got %0d expected %0d", d, i, bus.countdown, exp_cd); end
            vectors++; if (bus.race_active !== 1'b0) begin miscompares++; $display("FAIL cd_not_active d=%0d i=%0d: got %b expected 0", d, i, bus.race_active); end
            tick(1);
         end
      end
      bus.finish = 1'b0;
      vectors++; if (bus.race_active !== 1'b1) begin miscompares++; $display("FAIL cd_race_active: got %b expected 1", bus.race_active); end
      vectors++; if (bus.countdown !== 2'd0) begin miscompares++; $display("FAIL cd_race_countdown: got %0d expected 0", bus.countdown); end
   endtask

   task automatic test_hold_repress();
      int pulses;
      pulses = 0;
      do_reset();
      start_game();
      tick(12);
      set_btn(4'b0001);
      push_step(4'b0001);
      for (int i = 0; i < 10; i++) begin
         tick(1);
         pulses += int'(bus.step_green);
      end
      set_btn(4'b0000);
      tick(1); pulses += int'(bus.step_green);
      tick(1); pulses += int'(bus.step_green);
      set_btn(4'b0001);
      push_step(4'b0001);
      tick(1); pulses += int'(bus.step_green);
      vectors++; if (bus.step_green !== 1'b1) begin miscompares++; $display("FAIL repress_step: got %b expected 1", bus.step_green); end
      set_btn(4'b0000);
      tick(1); pulses += int'(bus.step_green);
      vectors++; if (bus.step_green !== 1'b0) begin miscompares++; $display("FAIL repress_width: got %b expected 0", bus.step_green); end
      tick(1); pulses += int'(bus.step_green);
      vectors++; if (pulses != 2) begin miscompares++; $display("FAIL hold_pulse_count: got %0d expected 2", pulses); end
   endtask

   task automatic test_false_start();
      do_reset();
      start_game();
      tick(4);
      vectors++; if (bus.countdown !== 2'd2) begin miscompares++; $display("FAIL fs_digit2: got %0d expected 2", bus.countdown); end
      set_btn(4'b0100);
      tick(1);
      set_btn(4'b0000);
      tick(1);
      vectors++; if (bus.false_start !== 4'b0100) begin miscompares++; $display("FAIL fs_flag: got %b expected 0100", bus.false_start); end
      vectors++; if (bus.countdown !== 2'd2) begin miscompares++; $display("FAIL fs_countdown_kept: got %0d expected 2", bus.countdown); end
      tick(6);
      vectors++; if (bus.race_active !== 1'b1) begin miscompares++; $display("FAIL fs_race_active: got %b expected 1", bus.race_active); end
      // Race cycle 1: red is clean and steps.
      set_btn(4'b0010);
      push_step(4'b0010);
      tick(1);
      // Race cycle 2: blue still penalised, dropped.
      set_btn(4'b0100);
      tick(1);
      set_btn(4'b0000);
      tick(4);
      // Race cycle 7: penalty over, blue steps.
      set_btn(4'b0100);
      push_step(4'b0100);
      tick(1);
      set_btn(4'b0000);
      tick(2);
      vectors++; if (bus.false_start !== 4'b0100) begin miscompares++; $display("FAIL fs_flag_held: got %b expected 0100", bus.false_start); end
   endtask

   task automatic test_all_and_finish();
      do_reset();
      start_game();
      tick(12);
      set_btn(4'b1111);
      push_step(4'b1111);
      tick(1);
      set_btn(4'b0000);
      tick(1);
      // finish with a simultaneous green press: no step, race ends.
      bus.finish = 1'b1;
      set_btn(4'b0001);
      tick(1);
      vectors++; if (bus.race_active !== 1'b0) begin miscompares++; $display("FAIL fin_race_active: got %b expected 0", bus.race_active); end
      bus.finish = 1'b0;
      set_btn(4'b0000);
      tick(1);
      set_btn(4'b1000);
      tick(1);
      set_btn(4'b0000);
      tick(4);
      // Red sampled in the last FINISHED cycle must not arm.
      set_btn(4'b0010);
      tick(1);
      set_btn(4'b0000);
      vectors++; if (bus.game_clear !== 1'b0) begin miscompares++; $display("FAIL fin_hold7: got %b expected 0", bus.game_clear); end
      tick(1);
      vectors++; if (bus.game_clear !== 1'b0) begin miscompares++; $display("FAIL fin_hold8: got %b expected 0", bus.game_clear); end
      // Now in IDLE: a press arms, release starts the countdown.
      set_btn(4'b0010);
      tick(1);
      set_btn(4'b0000);
      vectors++; if (bus.game_clear !== 1'b0) begin miscompares++; $display("FAIL fin_arm: got %b expected 0", bus.game_clear); end
      tick(1);
      vectors++; if (bus.game_clear !== 1'b1) begin miscompares++; $display("FAIL fin_idle_restart: got %b expected 1", bus.game_clear); end
      vectors++; if (bus.countdown !== 2'd3) begin miscompares++; $display("FAIL fin_restart_cd: got %0d expected 3", bus.countdown); end
   endtask

   task automatic test_reset_mid_countdown();
      do_reset();
      start_game();
      set_btn(4'b0100);
      tick(1);
      set_btn(4'b0000);
      tick(3);
      vectors++; if (bus.countdown !== 2'd2) begin miscompares++; $display("FAIL mid_pre_cd: got %0d expected 2", bus.countdown); end
      vectors++; if (bus.false_start !== 4'b0100) begin miscompares++; $display("FAIL mid_pre_fs: got %b expected 0100", bus.false_start); end
      rst_n = 1'b0;
      tick(1);
      vectors++; if (bus.countdown !== 2'd0) begin miscompares++; $display("FAIL mid_cd: got %0d expected 0", bus.countdown); end
      vectors++; if (bus.false_start !== 4'b0000) begin miscompares++; $display("FAIL mid_fs: got %b expected 0000", bus.false_start); end
      vectors++; if (bus.game_clear !== 1'b0) begin miscompares++; $display("FAIL mid_clear: got %b expected 0", bus.game_clear); end
      rst_n = 1'b1;
      for (int i = 0; i < 14; i++) begin
         tick(1);
         vectors++; if (bus.countdown !== 2'd0 || bus.game_clear !== 1'b0) begin miscompares++; $display("FAIL mid_idle i=%0d: got cd=%0d gc=%b expected cd=0 gc=0", i, bus.countdown, bus.game_clear); end
      end
      vectors++; if (bus.race_active !== 1'b0) begin miscompares++; $display("FAIL mid_no_race: got %b expected 0", bus.race_active); end
   endtask

   task automatic test_reset_kills_step();
      do_reset();
      start_game();
      tick(12);
      set_btn(4'b0001);
      rst_n = 1'b0;
      tick(1);
      vectors++; if (bus.step_green !== 1'b0) begin miscompares++; $display("FAIL rst_step: got %b expected 0", bus.step_green); end
      vectors++; if (bus.race_active !== 1'b0) begin miscompares++; $display("FAIL rst_step_race: got %b expected 0", bus.race_active); end
      rst_n = 1'b1;
      set_btn(4'b0000);
      tick(2);
   endtask

   initial begin
      rst_n      = 1'b0;
      bus.finish = 1'b0;
      set_btn(4'b0000);
      test_reset();
      test_countdown();
      test_hold_repress();
      test_false_start();
      test_all_and_finish();
      test_reset_mid_countdown();
      test_reset_kills_step();
      tick(2);
      vectors++; if (sb_q.size() != 0) begin miscompares++; $display("FAIL sb_drain: got %0d pending expected 0", sb_q.size()); end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
